hs4_client_rx: RTL

//  Synthesizable, clocked requester end of the 4-phase client_ready/server_ready nibble handshake.

---
 rtl/hs4_pkg.sv | 17 +
 rtl/hs4_nibble_fifo.sv | 60 ++++++
 rtl/hs4_client_rx.sv | 99 +++++++++
 3 files changed

// File: rtl/hs4_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// hs4_pkg - state encoding and defaults for the hs4 client receiver (rev 1.0)
// ----------------------------------------------------------------------
package hs4_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAITLOW = 2'd2
  } hs4_state_t;

  localparam int HS4_DW_DEFAULT    = 4;
  localparam int HS4_DEPTH_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/hs4_nibble_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------
// hs4_nibble_fifo - first-word-fall-through FIFO, power-of-two depth (rev 1.0)
// ----------------------------------------------------------------------
module hs4_nibble_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CW'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/hs4_client_rx.sv
`default_nettype none
// ----------------------------------------------------------------------
// hs4_client_rx - requester side of the 4-phase nibble handshake feeding a
// FIFO and valid/ready stream. Option: HS4_SYNC_EN adds a 2-flop input sync. (rev 1.0)
// ----------------------------------------------------------------------
module hs4_client_rx
  import hs4_pkg::*;
#(
  parameter int DW    = HS4_DW_DEFAULT,
  parameter int DEPTH = HS4_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  output logic                       client_ready,
  input  logic                       server_ready,
  input  logic [DW-1:0]              data,
  output logic                       out_valid,
  output logic [DW-1:0]              out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill_count,
  output logic                       proto_err
);

  localparam int CW = $clog2(DEPTH+1);

  hs4_state_t state;
  logic       srdy_s;
  logic       push;

`ifdef HS4_SYNC_EN
  logic [1:0] srdy_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      srdy_sync <= '0;
    end else begin
      srdy_sync <= {srdy_sync[0], server_ready};
    end
  end

  assign srdy_s = srdy_sync[1];
`else
  assign srdy_s = server_ready;
`endif

  assign push      = (state == S_REQ) && srdy_s;
  assign out_valid = (fill_count != '0);

  // client_ready is registered alongside state so it always equals (state == S_REQ).
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_WAITLOW;
      client_ready <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (srdy_s) begin
            proto_err <= 1'b1;
          end else if (en && (fill_count < CW'(DEPTH))) begin
            state        <= S_REQ;
            client_ready <= 1'b1;
          end
        end
        S_REQ: begin
          if (srdy_s) begin
            state        <= S_WAITLOW;
            client_ready <= 1'b0;
          end
        end
        S_WAITLOW: begin
          if (!srdy_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state        <= S_WAITLOW;
          client_ready <= 1'b0;
        end
      endcase
    end
  end

  hs4_nibble_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data),
    .pop       (out_ready),
    .head      (out_data),
    .count     (fill_count)
  );

endmodule
`default_nettype wire
